// File: rtl/dsr_align_pkg.sv
// dsr_align_pkg: state encoding, counter sizing helper and default timing for dsr_align_sched
package dsr_align_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CHRST, S_SETTLE, S_CHECK, S_SLIP, S_SLIPWAIT, S_NEXTCH, S_STRTPIPE, S_DONE
  } state_e;
  localparam int DEF_NCH = 8;
  localparam int DEF_RST_CYC = 4;
  localparam int DEF_WAIT_CYC = 6;
  localparam int DEF_CHK_CYC = 16;
  localparam int DEF_SLIP_MAX = 9;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/dsr_align_sched_maj3_vote.sv
// maj3_vote: bitwise 2-of-3 majority voter
module maj3_vote #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);
  assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/dsr_align_sched.sv
// dsr_align_sched: aligns deserializer channels one at a time (reset, settle, check, bit-slip), then restarts the pipeline.
// Define DSR_ALIGN_SCHED_TMR_EN to triplicate every register behind 2-of-3 majority voters.
module dsr_align_sched
  import dsr_align_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int RST_CYC  = DEF_RST_CYC,
  parameter int WAIT_CYC = DEF_WAIT_CYC,
  parameter int CHK_CYC  = DEF_CHK_CYC,
  parameter int SLIP_MAX = DEF_SLIP_MAX
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    PAT_OK,
  output logic [$clog2(NCH)-1:0]  CH_SEL,
  output logic [NCH-1:0]          DSR_RST,
  output logic [NCH-1:0]          BIT_SLIP,
  output logic [NCH-1:0]          ALIGNED,
  output logic [NCH-1:0]          FAIL,
  output logic                    BUSY,
  output logic                    STRT_PIPE,
  output logic                    DONE
);
  localparam int CHW = $clog2(NCH);
  localparam int CW = cnt_w(RST_CYC, WAIT_CYC, CHK_CYC);
  localparam int SW = $clog2(SLIP_MAX + 1);
  localparam logic [CW-1:0] RST_END = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] WAIT_END = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] CHK_END = CW'(CHK_CYC - 1);
  localparam logic [SW-1:0] SLIP_LIM = SW'(SLIP_MAX);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);
  typedef struct packed {
    state_e         st;
    logic [CHW-1:0] ch;
    logic [SW-1:0]  slip;
    logic [CW-1:0]  cnt;
    logic [NCH-1:0] dsr_rst;
    logic [NCH-1:0] bit_slip;
    logic [NCH-1:0] aligned;
    logic [NCH-1:0] fail;
    logic           busy;
    logic           strt_pipe;
    logic           done;
  } regs_t;
  regs_t r_d;
  regs_t rv;
  // cnt is the settle/reset timer outside Check and the consecutive-OK count inside it
  always_comb begin
    r_d = rv;
    case (rv.st)
      S_IDLE: if (START) begin
        r_d.st = S_CHRST;
        r_d.ch = '0;
        r_d.slip = '0;
        r_d.aligned = '0;
        r_d.fail = '0;
      end
      S_CHRST: r_d.st = (rv.cnt == RST_END) ? S_SETTLE : S_CHRST;
      S_SETTLE, S_SLIPWAIT: r_d.st = (rv.cnt == WAIT_END) ? S_CHECK : rv.st;
      S_CHECK: begin
        if (PAT_OK && rv.cnt == CHK_END) begin
          r_d.st = S_NEXTCH;
          r_d.aligned[rv.ch] = 1'b1;
        end else if (!PAT_OK && rv.slip < SLIP_LIM) begin
          r_d.st = S_SLIP;
        end else if (!PAT_OK) begin
          r_d.st = S_NEXTCH;
          r_d.fail[rv.ch] = 1'b1;
        end
      end
      S_SLIP: begin
        r_d.st = S_SLIPWAIT;
        r_d.slip = rv.slip + 1'b1;
      end
      S_NEXTCH: begin
        r_d.st = (rv.ch == CH_LAST) ? S_STRTPIPE : S_CHRST;
        r_d.ch = (rv.ch == CH_LAST) ? rv.ch : rv.ch + 1'b1;
        r_d.slip = (rv.ch == CH_LAST) ? rv.slip : '0;
      end
      S_STRTPIPE: r_d.st = S_DONE;
      default: r_d.st = S_IDLE;
    endcase
    r_d.cnt = (r_d.st != rv.st || rv.st == S_IDLE) ? '0 : rv.cnt + 1'b1;
    r_d.dsr_rst = (r_d.st == S_CHRST) ? NCH'(1) << r_d.ch : '0;
    r_d.bit_slip = (r_d.st == S_SLIP) ? NCH'(1) << r_d.ch : '0;
    r_d.busy = r_d.st != S_IDLE;
    r_d.strt_pipe = r_d.st == S_STRTPIPE;
    r_d.done = r_d.st == S_DONE;
  end
`ifdef DSR_ALIGN_SCHED_TMR_EN
  regs_t r_q [3];
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 3; i++) r_q[i] <= RST ? '0 : r_d;
  end
  maj3_vote #(.W($bits(regs_t))) u_vote (.a(r_q[0]), .b(r_q[1]), .c(r_q[2]), .y(rv));
`else
  regs_t r_q;
  always_ff @(posedge CLK) begin
    r_q <= RST ? '0 : r_d;
  end
  assign rv = r_q;
`endif
  assign CH_SEL = rv.ch;
  assign DSR_RST = rv.dsr_rst;
  assign BIT_SLIP = rv.bit_slip;
  assign ALIGNED = rv.aligned;
  assign FAIL = rv.fail;
  assign BUSY = rv.busy;
  assign STRT_PIPE = rv.strt_pipe;
  assign DONE = rv.done;
endmodule

// File: tb/tb_dsr_align_sched.sv
// tb_dsr_align_sched: directed sweeps with a per-sweep expectation queue checked on every DONE pulse
module tb_dsr_align_sched;
  logic clk = 0, rst = 1, start = 0, pat_ok = 1;
  logic [1:0] ch_sel;
  logic [3:0] dsr_rst, bit_slip, aligned, fail;
  logic busy, strt_pipe, done;
  dsr_align_sched #(.NCH(4), .RST_CYC(4), .WAIT_CYC(6), .CHK_CYC(16), .SLIP_MAX(9)) dut (
    .CLK(clk), .RST(rst), .START(start), .PAT_OK(pat_ok), .CH_SEL(ch_sel), .DSR_RST(dsr_rst),
    .BIT_SLIP(bit_slip), .ALIGNED(aligned), .FAIL(fail), .BUSY(busy), .STRT_PIPE(strt_pipe), .DONE(done)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0]  aligned;
    logic [3:0]  fail;
    logic [15:0] slips;
    logic [7:0]  d0;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int cyc = 0, mode = 0, done_n = 0, strt_n = 0, strt_sw = 0, strt_cyc = 0, viol = 0;
  int rst_last0 = 0, d0 = 0, last_slip = 0, min_gap = 1000;
  int rst_cnt[4] = '{default: 0};
  int slips[4] = '{default: 0};
  logic al0_prev = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_sweep();
    for (int i = 0; i < 4; i++) begin
      rst_cnt[i] = 0;
      slips[i] = 0;
    end
    last_slip = 0;
    min_gap = 1000;
    d0 = 0;
    viol = 0;
    strt_sw = 0;
  endtask
  // Monitor: gathers per-sweep observations, scores them on DONE, and plays the PAT_OK pattern
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (dsr_rst[i]) rst_cnt[i]++;
      if (bit_slip[i]) begin
        slips[i]++;
        if (last_slip != 0 && cyc - last_slip < min_gap) min_gap = cyc - last_slip;
        last_slip = cyc;
      end
    end
    if (dsr_rst[0]) rst_last0 = cyc;
    if (aligned[0] && !al0_prev) d0 = cyc - rst_last0;
    al0_prev = aligned[0];
    if (!$onehot0(dsr_rst) || !$onehot0(bit_slip) || (aligned & fail) != 0) viol++;
    if (strt_pipe) begin
      strt_n++;
      strt_sw++;
      strt_cyc = cyc;
    end
    if (done) begin
      done_n++;
      check("done_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("aligned", aligned, e.aligned);
        check("fail", fail, e.fail);
        for (int i = 0; i < 4; i++) begin
          check($sformatf("slips_ch%0d", i), slips[i], e.slips[4*i +: 4]);
          check($sformatf("rst_cycles_ch%0d", i), rst_cnt[i], 4);
        end
        check("ch0_align_latency", d0, e.d0);
        check("invariants", viol, 0);
        check("strt_pipe_count", strt_sw, 1);
        check("strt_to_done", cyc - strt_cyc, 1);
        check("busy_at_done", busy, 1);
        if (e.slips != 0) check("slip_gap_ge7", min_gap >= 7, 1);
      end
      clear_sweep();
    end
    if (rst) clear_sweep();
    case (mode)
      1: pat_ok = !(ch_sel == 2 && slips[2] < 3);
      2: pat_ok = ch_sel != 1;
      3: pat_ok = cyc != rst_last0 + 16;
      default: pat_ok = 1'b1;
    endcase
  end
  task automatic wait_done();
    int n0 = done_n;
    int k = 0;
    while (done_n == n0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done_n != n0, 1);
    @(negedge clk);
    check("busy_off", busy, 0);
  endtask
  task automatic sweep(input int m, input exp_t e, input bit poke);
    mode = m;
    q.push_back(e);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    check("busy_on", busy, 1);
    check("ch0_rst_first", dsr_rst, 4'b0001);
    if (poke) begin
      repeat (30) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_done();
  endtask
  initial begin
    int k, n0, s0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {ch_sel, dsr_rst, bit_slip, aligned, fail, busy, strt_pipe, done}, 0);
    rst = 0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    sweep(0, {4'hF, 4'h0, 16'h0000, 8'd23}, 1);
    sweep(1, {4'hF, 4'h0, 16'h0300, 8'd23}, 0);
    sweep(2, {4'b1101, 4'b0010, 16'h0090, 8'd23}, 0);
    sweep(3, {4'hF, 4'h0, 16'h0001, 8'd40}, 0);
    mode = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    k = 0;
    while (ch_sel != 1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("reach_ch1", ch_sel, 1);
    k = 0;
    while (dsr_rst != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    check("busy_start_ch", ch_sel, 1);
    check("busy_start_rst", dsr_rst, 0);
    check("ch0_aligned_pre_rst", aligned, 4'b0001);
    n0 = done_n;
    s0 = strt_n;
    rst = 1;
    @(negedge clk);
    check("mid_rst_outputs", {ch_sel, dsr_rst, bit_slip, aligned, fail, busy, strt_pipe, done}, 0);
    rst = 0;
    repeat (100) @(negedge clk);
    check("no_done_after_rst", done_n, n0);
    check("no_strt_after_rst", strt_n, s0);
    rst = 1;
    start = 1;
    @(negedge clk);
    check("rst_wins_busy", busy, 0);
    check("rst_wins_dsr", dsr_rst, 0);
    rst = 0;
    start = 0;
    repeat (3) @(negedge clk);
    check("rst_wins_idle", busy, 0);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
